// File: rtl/dm_cache_ctrl.sv
// Direct-mapped, write-back, write-allocate cache controller, one word per line.
// Handles a single outstanding CPU request with dirty-line write-back ahead of the line fetch.
`timescale 1ns/1ps
module dm_cache_ctrl #(
   parameter int ADDR_W  = 8,
   parameter int DATA_W  = 8,
   parameter int INDEX_W = 2,
   parameter int CNT_W   = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              cpu_req_valid,
   input  logic              cpu_req_rw,
   input  logic [ADDR_W-1:0] cpu_req_addr,
   input  logic [DATA_W-1:0] cpu_req_datain,
   output logic [DATA_W-1:0] cpu_req_dataout,
   output logic              cpu_resp_valid,
   output logic              cache_ready,
   output logic              mem_req_valid,
   output logic              mem_req_rw,
   output logic [ADDR_W-1:0] mem_req_addr,
   output logic [DATA_W-1:0] mem_req_dataout,
   input  logic [DATA_W-1:0] mem_req_datain,
   input  logic              mem_req_ready,
   output logic [CNT_W-1:0]  hit_cnt,
   output logic [CNT_W-1:0]  miss_cnt
);
   // state      | meaning
   // IDLE       | waiting for a CPU request (cache_ready high)
   // COMPARE    | tag lookup on the latched request
   // WRITE_BACK | dirty victim being written to memory
   // ALLOCATE   | line fetch for the latched address
   localparam int TAG_W = ADDR_W - INDEX_W;
   localparam int LINES = 1 << INDEX_W;

   typedef enum logic [1:0] {IDLE, COMPARE, WRITE_BACK, ALLOCATE} state_t;

   state_t             state;
   logic [ADDR_W-1:0]  req_addr;
   logic [DATA_W-1:0]  req_data;
   logic               req_rw;
   logic [DATA_W-1:0]  data_arr [LINES];
   logic [TAG_W-1:0]   tag_arr  [LINES];
   logic [LINES-1:0]   line_valid;
   logic [LINES-1:0]   line_dirty;
   logic [INDEX_W-1:0] idx;
   logic [TAG_W-1:0]   tag;
   logic               hit;
   logic               fill_done;

   assign idx         = req_addr[INDEX_W-1:0];
   assign tag         = req_addr[ADDR_W-1:INDEX_W];
   assign hit         = line_valid[idx] && (tag_arr[idx] == tag);
   assign fill_done   = (state == ALLOCATE) && mem_req_ready;
   assign cache_ready = (state == IDLE);

   // Data and tag storage carry no reset; line_valid guards their contents.
   always_ff @(posedge clk) begin
      if (state == COMPARE && hit && req_rw)
         data_arr[idx] <= req_data;
      if (fill_done) begin
         tag_arr[idx]  <= tag;
         data_arr[idx] <= req_rw ? req_data : mem_req_datain;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state           <= IDLE;
         req_addr        <= '0;
         req_data        <= '0;
         req_rw          <= 1'b0;
         line_valid      <= '0;
         line_dirty      <= '0;
         cpu_req_dataout <= '0;
         cpu_resp_valid  <= 1'b0;
         hit_cnt         <= '0;
         miss_cnt        <= '0;
      end else begin
         cpu_resp_valid <= 1'b0;
         case (state)
            IDLE: begin
               if (cpu_req_valid) begin
                  req_addr <= cpu_req_addr;
                  req_data <= cpu_req_datain;
                  req_rw   <= cpu_req_rw;
                  state    <= COMPARE;
               end
            end
            COMPARE: begin
               if (hit) begin
                  if (req_rw)
                     line_dirty[idx] <= 1'b1;
                  else
                     cpu_req_dataout <= data_arr[idx];
                  cpu_resp_valid <= 1'b1;
                  if (hit_cnt != '1)
                     hit_cnt <= hit_cnt + CNT_W'(1);
                  state <= IDLE;
               end else begin
                  if (miss_cnt != '1)
                     miss_cnt <= miss_cnt + CNT_W'(1);
                  state <= (line_valid[idx] && line_dirty[idx]) ? WRITE_BACK : ALLOCATE;
               end
            end
            WRITE_BACK: begin
               if (mem_req_ready)
                  state <= ALLOCATE;
            end
            ALLOCATE: begin
               if (mem_req_ready) begin
                  line_valid[idx] <= 1'b1;
                  line_dirty[idx] <= req_rw;
                  if (!req_rw)
                     cpu_req_dataout <= mem_req_datain;
                  cpu_resp_valid <= 1'b1;
                  state          <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   // Memory port is decoded from state so it drops as soon as reset clears the state.
   always_comb begin
      mem_req_valid   = 1'b0;
      mem_req_rw      = 1'b0;
      mem_req_addr    = req_addr;
      mem_req_dataout = '0;
      case (state)
         WRITE_BACK: begin
            mem_req_valid   = 1'b1;
            mem_req_rw      = 1'b1;
            mem_req_addr    = {tag_arr[idx], idx};
            mem_req_dataout = data_arr[idx];
         end
         ALLOCATE: begin
            mem_req_valid = 1'b1;
         end
         default: ;
      endcase
   end
endmodule

// File: doc/dm_cache_ctrl.md
Name: dm_cache_ctrl

Overview:
Parametrised direct-mapped, write-back, write-allocate cache controller between a single CPU request port and a main-memory port.
- One data word per line, single outstanding request.
- Full memory handshake with dirty-line write-back.
- Saturating hit/miss counters for performance observation.
- Sits between the CPU core and the main-memory model/arbiter.

Parameters:
ADDR_W, 8, CPU/memory address width in bits
DATA_W, 8, data word width in bits
INDEX_W, 2, index bits; number of lines = 2**INDEX_W; tag width = ADDR_W-INDEX_W (index = addr[INDEX_W-1:0], tag = addr[ADDR_W-1:INDEX_W])
CNT_W, 16, width of the hit/miss counters

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous, active-high reset
cpu_req_valid  in  1  CPU request strobe
cpu_req_rw  in  1  1=write, 0=read
cpu_req_addr  in  ADDR_W  request address
cpu_req_datain  in  DATA_W  write data
cpu_req_dataout  out  DATA_W  read data, registered
cpu_resp_valid  out  1  one-cycle pulse: request complete
cache_ready  out  1  high when IDLE (request can be accepted)
mem_req_valid  out  1  memory request strobe
mem_req_rw  out  1  1=write-back, 0=line fetch
mem_req_addr  out  ADDR_W  memory address
mem_req_dataout  out  DATA_W  write-back data
mem_req_datain  in  DATA_W  fetched data, valid when mem_req_ready=1
mem_req_ready  in  1  memory completes the current request at this edge
hit_cnt  out  CNT_W  saturating hit counter
miss_cnt  out  CNT_W  saturating miss counter

Behaviour:
- Reset (async, rst=1):
  - State goes to IDLE; all valid and dirty bits are cleared.
  - cpu_req_dataout=0, cpu_resp_valid=0, hit_cnt=0, miss_cnt=0, mem_req_valid=0.
  - The data and tag arrays are not reset.
  - cache_ready=1, but requests are ignored while rst=1.
- States: IDLE, COMPARE, WRITE_BACK, ALLOCATE. cache_ready = (state==IDLE).
- IDLE:
  - At an edge with cpu_req_valid=1, latch addr, datain and rw, then go to COMPARE.
  - cpu_req_valid is ignored in every other state; no queuing.
- COMPARE: hit = valid[idx] && tag[idx]==latched tag.
  - Read hit: cpu_req_dataout<=data[idx], pulse resp, hit_cnt++, go to IDLE.
  - Write hit: data[idx]<=wdata, dirty[idx]<=1, pulse resp, hit_cnt++, go to IDLE.
  - Miss: miss_cnt++. If valid[idx]&&dirty[idx], go to WRITE_BACK; otherwise go to ALLOCATE.
- WRITE_BACK:
  - Outputs: mem_req_valid=1, mem_req_rw=1, mem_req_addr={tag[idx],idx}, mem_req_dataout=data[idx].
  - Hold until mem_req_ready=1, then go to ALLOCATE.
- ALLOCATE:
  - Outputs: mem_req_valid=1, mem_req_rw=0, mem_req_addr=latched addr.
  - Complete at the edge where mem_req_ready=1: tag[idx]<=tag, valid[idx]<=1.
  - Read: data[idx]<=mem_req_datain, dirty<=0, cpu_req_dataout<=mem_req_datain.
  - Write: data[idx]<=wdata, dirty<=1; the fetched word is discarded.
  - Pulse resp and go to IDLE.
- mem_req_* outputs:
  - Decoded from state and registers; stable for the whole state.
  - mem_req_rw and mem_req_dataout are don't-care (drive 0) while mem_req_valid=0.
- Latency, with the request accepted at edge N:
  - Hit: resp and cache_ready high after edge N+1.
  - Clean miss: mem_req_valid high after edge N+1; resp at the edge where mem_req_ready is sampled high.
  - Dirty miss: the write-back transfer precedes the fetch; there is at least one cycle of mem_req_valid per transfer.
- cpu_req_dataout holds its value until the next read completes; writes never change it.
- Counters saturate at all-ones; they never wrap.
- mem_req_ready sampled outside WRITE_BACK/ALLOCATE is ignored.
- Reset mid-operation:
  - mem_req_valid drops immediately (async).
  - No resp is issued, and dirty data is lost.
  - The next access to that address misses.

Test Plan:
- INDEX_W=2. Reset; read 0xA4 (idx0) with memory returning 0xBE after 3 wait cycles -> exactly one fetch at 0xA4 (rw=0), resp with dataout=0xBE, miss_cnt=1, hit_cnt=0.
- Read 0xA4 again -> no mem_req_valid; resp one cycle after accept, dataout=0xBE, hit_cnt=1.
- Write 0xC0 to 0xA4 (hit), then read 0xA8 (same idx0, different tag) -> write-back at 0xA4 with data 0xC0, then fetch at 0xA8; miss_cnt=2.
- Write 0x5A to 0x05 (clean miss) -> fetch at 0x05, fetched data discarded; a subsequent read of 0x05 hits with dataout=0x5A and no memory traffic.
- Hold cpu_req_valid=1 continuously during a miss with differing addr -> only the first request is processed; a new accept occurs only once cache_ready=1.
- Assert rst while in ALLOCATE -> mem_req_valid=0 immediately, no resp, counters=0; re-reading the same address misses.
- With CNT_W=2, perform 5 hits -> hit_cnt saturates at 3.
